// File: rtl/lane_lfu_issue_seq_if.sv
// Issue-queue to LFU-expand bundle for lane_lfu_issue_seq.
// master: issue queue side (drives op_*, observes op_rdy and status).
// slave : sequencer side (drives op_rdy, expand_*, busy, idle).
interface lane_lfu_issue_seq_if #(
  parameter int unsigned SZ_BVLEN   = 6,
  parameter int unsigned SZ_VAU0_FN = 11,
  parameter int unsigned SZ_VAU1_FN = 8,
  parameter int unsigned SZ_VAU2_FN = 4
);
  localparam int unsigned SZ_FN01 = (SZ_VAU0_FN > SZ_VAU1_FN) ? SZ_VAU0_FN : SZ_VAU1_FN;
  localparam int unsigned SZ_FN   = (SZ_FN01 > SZ_VAU2_FN) ? SZ_FN01 : SZ_VAU2_FN;

  logic                  op_val;
  logic                  op_rdy;
  logic [2:0]            op_fu;
  logic [SZ_FN-1:0]      op_fn;
  logic [SZ_BVLEN-1:0]   op_cnt;

  logic                  expand_vau0;
  logic                  expand_vau1;
  logic                  expand_vau2;
  logic                  expand_vldq;
  logic                  expand_vsdq;
  logic                  expand_utaq;
  logic                  expand_utldq;
  logic                  expand_utsdq;
  logic [SZ_VAU0_FN-1:0] expand_vau0_fn;
  logic [SZ_VAU1_FN-1:0] expand_vau1_fn;
  logic [SZ_VAU2_FN-1:0] expand_vau2_fn;
  logic [SZ_BVLEN-1:0]   expand_rcnt;
  logic [SZ_BVLEN-1:0]   expand_wcnt;
  logic [5:0]            busy;
  logic                  idle;

  modport master (
    output op_val, op_fu, op_fn, op_cnt,
    input  op_rdy,
    input  expand_vau0, expand_vau1, expand_vau2, expand_vldq, expand_vsdq,
    input  expand_utaq, expand_utldq, expand_utsdq,
    input  expand_vau0_fn, expand_vau1_fn, expand_vau2_fn,
    input  expand_rcnt, expand_wcnt, busy, idle
  );

  modport slave (
    input  op_val, op_fu, op_fn, op_cnt,
    output op_rdy,
    output expand_vau0, expand_vau1, expand_vau2, expand_vldq, expand_vsdq,
    output expand_utaq, expand_utldq, expand_utsdq,
    output expand_vau0_fn, expand_vau1_fn, expand_vau2_fn,
    output expand_rcnt, expand_wcnt, busy, idle
  );
endinterface

// File: rtl/lane_lfu_issue_seq.sv
// Lane LFU issue sequencer: accepts one micro-op per cycle and emits a
// registered one-cycle expand pulse, keeping shadow countdowns that mirror
// the LFU per-unit counters so a unit is never re-issued while busy.
// Ports: clk, reset (sync, active-high), bus (slave side of
// lane_lfu_issue_seq_if: op_* handshake in, expand_*/busy/idle out).
module lane_lfu_issue_seq #(
  parameter int unsigned SZ_BVLEN   = 6,
  parameter int unsigned SZ_VAU0_FN = 11,
  parameter int unsigned SZ_VAU1_FN = 8,
  parameter int unsigned SZ_VAU2_FN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  lane_lfu_issue_seq_if.slave    bus
);
  localparam int unsigned N_CNT  = 6;
  localparam int unsigned N_FU   = 8;
  localparam int unsigned W_SEL  = 3;

  // Counter indices match busy bit order {vsu, vlu, vgu, vau2, vau1, vau0}.
  localparam logic [W_SEL-1:0] C_VAU0 = 3'd0;
  localparam logic [W_SEL-1:0] C_VAU1 = 3'd1;
  localparam logic [W_SEL-1:0] C_VAU2 = 3'd2;
  localparam logic [W_SEL-1:0] C_VGU  = 3'd3;
  localparam logic [W_SEL-1:0] C_VLU  = 3'd4;
  localparam logic [W_SEL-1:0] C_VSU  = 3'd5;

  logic [N_CNT-1:0][SZ_BVLEN-1:0] shadow;
  logic [N_FU-1:0]                pulse;
  logic [W_SEL-1:0]               sel;
  logic                           accept;
  logic                           is_load;

  // Map target unit to its shadow counter; load queues share one counter.
  always_comb begin
    sel = C_VAU0;
    case (bus.op_fu)
      3'd0: sel = C_VAU0;
      3'd1: sel = C_VAU1;
      3'd2: sel = C_VAU2;
      3'd3: sel = C_VLU;
      3'd4: sel = C_VSU;
      3'd5: sel = C_VGU;
      3'd6: sel = C_VLU;
      3'd7: sel = C_VSU;
      default: sel = C_VAU0;
    endcase
  end

  assign bus.op_rdy = !reset && (shadow[sel] == '0);
  assign accept     = bus.op_val && bus.op_rdy;
  assign is_load    = (bus.op_fu == 3'd3) || (bus.op_fu == 3'd6);

  // Shadow counters, pulse and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow          <= '0;
      pulse           <= '0;
      bus.expand_rcnt <= '0;
      bus.expand_wcnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if (accept && (sel == W_SEL'(i)))
          shadow[i] <= bus.op_cnt;
        else if (shadow[i] != '0)
          shadow[i] <= shadow[i] - SZ_BVLEN'(1);
      end
      pulse           <= accept ? (N_FU'(1) << bus.op_fu) : '0;
      bus.expand_rcnt <= (accept && !is_load) ? bus.op_cnt : '0;
      bus.expand_wcnt <= (accept &&  is_load) ? bus.op_cnt : '0;
    end
  end

  // Function buses hold between pulses and carry no reset.
  always_ff @(posedge clk) begin
    if (accept && (bus.op_fu == 3'd0)) bus.expand_vau0_fn <= bus.op_fn[SZ_VAU0_FN-1:0];
    if (accept && (bus.op_fu == 3'd1)) bus.expand_vau1_fn <= bus.op_fn[SZ_VAU1_FN-1:0];
    if (accept && (bus.op_fu == 3'd2)) bus.expand_vau2_fn <= bus.op_fn[SZ_VAU2_FN-1:0];
  end

  assign bus.expand_vau0  = pulse[0];
  assign bus.expand_vau1  = pulse[1];
  assign bus.expand_vau2  = pulse[2];
  assign bus.expand_vldq  = pulse[3];
  assign bus.expand_vsdq  = pulse[4];
  assign bus.expand_utaq  = pulse[5];
  assign bus.expand_utldq = pulse[6];
  assign bus.expand_utsdq = pulse[7];

  always_comb begin
    bus.busy = '0;
    for (int unsigned i = 0; i < N_CNT; i++)
      bus.busy[i] = (shadow[i] != '0);
  end

  assign bus.idle = (bus.busy == '0) && (pulse == '0);
endmodule
